imem_cache: RTL and testbench

Direct-mapped instruction cache that answers the fetch stage's instruction-memory address.
- Lookup is combinational, so a hit returns its instruction in the same cycle as `imem_addr_F`.
- On a miss it asserts `stall_F`; the core ties `stall_F` low-active into the fetch stage's PC `enable`.
- While stalled, it refills one line from the backing instruction memory over a req/ack beat handshake.

---
 rtl/imem_cache_pkg.sv | 17 +
 rtl/imem_cache_array.sv | 54 +++++
 rtl/imem_cache.sv | 129 ++++++++++++
 tb/tb_imem_cache.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package imem_cache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/imem_cache_array.sv
// Tag/valid/data storage: asynchronous read, synchronous write, valid bits cleared on reset.
module imem_cache_array #(
  parameter int W     = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int TAGW  = 57,
  parameter int IDX   = 3,
  parameter int OFF   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDX-1:0]  rd_idx,
  input  logic [OFF-1:0]  rd_off,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [W-1:0]    rd_data,
  input  logic [IDX-1:0]  wr_idx,
  input  logic [OFF-1:0]  wr_off,
  input  logic            data_we,
  input  logic [W-1:0]    wr_data,
  input  logic            line_we,
  input  logic [TAGW-1:0] wr_tag
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [W-1:0]     data_q [LINES][WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  // Reset wins over a same-cycle line completion so an abandoned refill never becomes valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_cache.sv
// Direct-mapped instruction cache: combinational hit lookup, stall on miss,
// and a one-line refill over a req/ack beat handshake.
module imem_cache
  import imem_cache_pkg::*;
#(
  parameter int N     = 64,
  parameter int W     = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] imem_addr_F,
  output logic [W-1:0] instr_F,
  output logic         stall_F,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata
);

  localparam int OFF  = off_bits(WORDS);
  localparam int IDX  = idx_bits(LINES);
  localparam int TAGW = N - OFF - IDX - 2;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [OFF-1:0]  beat_q, beat_d;
  logic [TAGW-1:0] rf_tag_q, rf_tag_d;
  logic [IDX-1:0]  rf_idx_q, rf_idx_d;

  logic [OFF-1:0]  a_off;
  logic [IDX-1:0]  a_idx;
  logic [TAGW-1:0] a_tag;
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  logic [W-1:0]    rd_data;
  logic            hit;
  logic            data_we;
  logic            line_we;
  logic            unused_addr_bits;

  assign a_off = imem_addr_F[OFF+1:2];
  assign a_idx = imem_addr_F[OFF+IDX+1:OFF+2];
  assign a_tag = imem_addr_F[N-1:OFF+IDX+2];
  assign unused_addr_bits = ^imem_addr_F[1:0];

  imem_cache_array #(
    .W     (W),
    .LINES (LINES),
    .WORDS (WORDS),
    .TAGW  (TAGW),
    .IDX   (IDX),
    .OFF   (OFF)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (a_idx),
    .rd_off   (a_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_idx   (rf_idx_q),
    .wr_off   (beat_q),
    .data_we  (data_we),
    .wr_data  (mem_rdata),
    .line_we  (line_we),
    .wr_tag   (rf_tag_q)
  );

  assign hit = rd_valid && (rd_tag == a_tag);

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    beat_d    = beat_q;
    rf_tag_d  = rf_tag_q;
    rf_idx_d  = rf_idx_q;
    data_we   = 1'b0;
    line_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d   = REFILL;
          mem_req_d = 1'b1;
          rf_tag_d  = a_tag;
          rf_idx_d  = a_idx;
          beat_d    = '0;
        end
      end
      REFILL: begin
        // The refill follows the latched line; fetch redirects are not observed here.
        if (mem_ack) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            line_we   = 1'b1;
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      beat_q    <= '0;
      rf_tag_q  <= '0;
      rf_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      beat_q    <= beat_d;
      rf_tag_q  <= rf_tag_d;
      rf_idx_q  <= rf_idx_d;
    end
  end

  assign stall_F  = !((state_q == IDLE) && hit);
  assign instr_F  = stall_F ? '0 : rd_data;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_req_q ? {rf_tag_q, rf_idx_q, beat_q, 2'b00} : '0;

endmodule

// File: tb/tb_imem_cache.sv
// Scoreboard bench for imem_cache: the driver queues expected hits and refill beats,
// a monitor checks them as the cache presents them, and a memory model acks beats.
module tb_imem_cache;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] imem_addr_F = '0;
  logic [31:0] instr_F;
  logic        stall_F;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_period = 1;
  logic [63:0] exp_beat[$];
  logic [31:0] exp_instr[$];

  imem_cache dut (
    .clk         (clk),
    .reset       (rst),
    .imem_addr_F (imem_addr_F),
    .instr_F     (instr_F),
    .stall_F     (stall_F),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return 32'hA0 + a[33:2];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_line(input logic [63:0] a);
    logic [63:0] base;
    base = a & ~64'hF;
    for (int i = 0; i < 4; i++) exp_beat.push_back(base + 64'(4 * i));
  endtask

  // Backing memory: acks every ack_period-th cycle of an outstanding request.
  initial begin : memory_model
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (wait_cnt == ack_period - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_data(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (stall_F) begin
          check("instr_zero_on_stall", 64'(instr_F), 64'h0);
        end else if (exp_instr.size() == 0) begin
          check("unexpected_hit", 64'(instr_F), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ei = exp_instr.pop_front();
          check("hit_instr", 64'(instr_F), 64'(ei));
        end
        if (mem_req) begin
          if (exp_beat.size() == 0) begin
            check("unexpected_req", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("beat_addr", mem_addr, exp_beat[0]);
            if (mem_ack) void'(exp_beat.pop_front());
          end
        end else begin
          check("addr_idle_zero", mem_addr, 64'h0);
        end
      end
    end
  end

  // Starts at a negedge, returns at the negedge after the hit cycle.
  task automatic fetch(input logic [63:0] a, input logic miss, input int exp_cyc);
    int cyc;
    imem_addr_F = a;
    if (miss) push_line(a);
    exp_instr.push_back(mem_data(a));
    cyc = 0;
    #2;
    while (stall_F && cyc < LIMIT) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("fetch_latency", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
  endtask

  task automatic wait_acks(input int n);
    int acks;
    int cyc;
    acks = 0;
    cyc  = 0;
    while (acks < n && cyc < LIMIT) begin
      @(negedge clk);
      #2;
      if (mem_ack) acks++;
      cyc++;
    end
    check("ack_wait", 64'(acks), 64'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int cyc;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 64'(stall_F), 64'h1);
    check("reset_instr", 64'(instr_F), 64'h0);
    check("reset_req", 64'(mem_req), 64'h0);
    check("reset_mem_addr", mem_addr, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss, then same-line hits
    fetch(64'h0, 1'b1, 5);
    fetch(64'h4, 1'b0, 0);
    fetch(64'h8, 1'b0, 0);
    fetch(64'hC, 1'b0, 0);

    // conflict on index 0
    fetch(64'h80, 1'b1, 5);
    fetch(64'h84, 1'b0, 0);
    fetch(64'h0, 1'b1, 5);

    // wait states: ack every third cycle
    ack_period = 3;
    fetch(64'h30, 1'b1, 13);
    ack_period = 1;
    fetch(64'h34, 1'b0, 0);
    fetch(64'h38, 1'b0, 0);
    fetch(64'h3C, 1'b0, 0);

    // redirect after beat 1 of a refill at 0x40
    imem_addr_F = 64'h40;
    push_line(64'h40);
    push_line(64'h100);
    exp_instr.push_back(mem_data(64'h100));
    wait_acks(2);
    @(negedge clk);
    imem_addr_F = 64'h100;
    cyc = 0;
    #2;
    while (stall_F && cyc < LIMIT) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("redirect_latency", 64'(cyc), 64'd7);
    @(negedge clk);
    fetch(64'h44, 1'b0, 0);
    fetch(64'h108, 1'b0, 0);

    // reset after two beats of a refill at 0x20
    imem_addr_F = 64'h20;
    push_line(64'h20);
    wait_acks(2);
    @(negedge clk);
    rst = 1'b1;
    exp_beat.delete();
    @(negedge clk);
    #1;
    check("req_after_reset", 64'(mem_req), 64'h0);
    check("stall_after_reset", 64'(stall_F), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    fetch(64'h20, 1'b1, 5);
    fetch(64'h40, 1'b1, 5);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("beat_queue_empty", 64'(exp_beat.size()), 64'h0);
    check("instr_queue_empty", 64'(exp_instr.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
